// File: rtl/add_tree_acc.sv
// Pipelined signed saturating adder tree over N lanes with an optional group accumulator.
// A delay-matched bypass carries in_0_flat and valid_in alongside the sums.
module add_tree_acc #(
  parameter int N         = 8,
  parameter int W         = 16,
  parameter bit ACC_EN    = 1'b1,
  parameter int MAX_BEATS = 64,
  localparam int CW       = $clog2(MAX_BEATS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            valid_in,
  input  logic            last_in,
  input  logic [N*W-1:0]  in_0_flat,
  input  logic [N*W-1:0]  in_1_flat,
  output logic [W-1:0]    sum_out,
  output logic            sum_valid,
  output logic            sat_flag,
  output logic [CW-1:0]   beats_out,
  output logic            valid_bypass_out,
  output logic [N*W-1:0]  in_bypass_flat
);

  localparam int S = (N > 1) ? $clog2(N) : 1;
  localparam int L = S + 1;

  // Returns {clamped, sum}: W+1-bit signed add clamped back into W bits.
  function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) sat_add = {1'b1, s[W], {(W-1){~s[W]}}};
    else                sat_add = {1'b0, s[W-1:0]};
  endfunction

  // Level k pairs elements 2i/2i+1; an odd leftover is registered unchanged.
  for (genvar k = 0; k < S; k++) begin : g_lvl
    localparam int NI = (N + (1 << k) - 1) >> k;
    localparam int NO = (NI + 1) / 2;
    logic [W-1:0] src     [NI];
    logic         src_sat [NI];
    logic [W-1:0] data_d  [NO];
    logic [W-1:0] data_q  [NO];
    logic         sat_d   [NO];
    logic         sat_q   [NO];

    for (genvar i = 0; i < NI; i++) begin : g_src
      if (k == 0) begin : g_in
        assign src[i]     = in_1_flat[i*W +: W];
        assign src_sat[i] = 1'b0;
      end else begin : g_prev
        assign src[i]     = g_lvl[k-1].data_q[i];
        assign src_sat[i] = g_lvl[k-1].sat_q[i];
      end
    end

    for (genvar i = 0; i < NO; i++) begin : g_node
      if (2*i + 1 < NI) begin : g_pair
        logic [W:0] r;
        assign r         = sat_add(src[2*i], src[2*i+1]);
        assign data_d[i] = r[W-1:0];
        assign sat_d[i]  = r[W] | src_sat[2*i] | src_sat[2*i+1];
      end else begin : g_pass
        assign data_d[i] = src[2*i];
        assign sat_d[i]  = src_sat[2*i];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < NO; i++) begin
          data_q[i] <= '0;
          sat_q[i]  <= 1'b0;
        end
      end else if (en) begin
        data_q <= data_d;
        sat_q  <= sat_d;
      end
    end
  end

  // valid_in qualifies a beat (and its last_in); there is no backpressure, en stalls everything.
  logic [S-1:0]  vld_q;
  logic [S-1:0]  lst_q;
  logic [N*W:0]  byp_q [L];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      lst_q <= '0;
      for (int k = 0; k < L; k++) byp_q[k] <= '0;
    end else if (en) begin
      vld_q[0] <= valid_in;
      lst_q[0] <= valid_in & last_in;
      for (int k = 1; k < S; k++) begin
        vld_q[k] <= vld_q[k-1];
        lst_q[k] <= lst_q[k-1];
      end
      byp_q[0] <= {valid_in, in_0_flat};
      for (int k = 1; k < L; k++) byp_q[k] <= byp_q[k-1];
    end
  end

  assign valid_bypass_out = byp_q[L-1][N*W];
  assign in_bypass_flat   = byp_q[L-1][N*W-1:0];

  logic [W-1:0] t_val;
  logic         t_sat;
  logic         t_vld;
  logic         t_lst;
  assign t_val = g_lvl[S-1].data_q[0];
  assign t_sat = g_lvl[S-1].sat_q[0];
  assign t_vld = vld_q[S-1];
  assign t_lst = lst_q[S-1];

  typedef enum logic {FIRST = 1'b0, ACCUM = 1'b1} acc_state_e;
  acc_state_e    state_q, state_d;
  logic [W-1:0]  acc_q, acc_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d, beats_q, beats_d;
  logic          gsat_q, gsat_d, satf_q, satf_d, sv_q, sv_d;
  logic [W:0]    acc_sum;
  logic          close;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    gsat_d  = gsat_q;
    sum_d   = sum_q;
    beats_d = beats_q;
    satf_d  = satf_q;
    sv_d    = 1'b0;
    close   = 1'b0;
    acc_sum = sat_add(acc_q, t_val);
    if (t_vld) begin
      if (state_q == FIRST) begin
        acc_d  = t_val;
        cnt_d  = CW'(1);
        gsat_d = t_sat;
      end else begin
        acc_d  = acc_sum[W-1:0];
        cnt_d  = cnt_q + 1'b1;
        gsat_d = gsat_q | t_sat | acc_sum[W];
      end
      // A full group closes even without last so the counter never wraps.
      close = t_lst || !ACC_EN || (cnt_d == CW'(MAX_BEATS));
      if (close) begin
        sum_d   = acc_d;
        beats_d = cnt_d;
        satf_d  = gsat_d;
        sv_d    = 1'b1;
        state_d = FIRST;
      end else begin
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FIRST;
      acc_q   <= '0;
      cnt_q   <= '0;
      gsat_q  <= 1'b0;
      sum_q   <= '0;
      beats_q <= '0;
      satf_q  <= 1'b0;
      sv_q    <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      gsat_q  <= gsat_d;
      sum_q   <= sum_d;
      beats_q <= beats_d;
      satf_q  <= satf_d;
      sv_q    <= sv_d;
    end
  end

  assign sum_out   = sum_q;
  assign beats_out = beats_q;
  assign sat_flag  = satf_q;
  assign sum_valid = sv_q;

endmodule

// File: tb/tb_add_tree_acc.sv
// Bench for add_tree_acc: three configurations share one stimulus stream and are
// checked every cycle against a group-level model of the reduction and accumulation.
module tb_add_tree_acc;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         valid_in = 1'b0;
  logic         last_in = 1'b0;
  logic [127:0] in_0_flat = '0;
  logic [127:0] in_1_flat = '0;

  always #5 clk = ~clk;

  logic [15:0]  sum0, sum1, sum2;
  logic         sv0, sv1, sv2, sat0, sat1, sat2, vb0, vb1, vb2;
  logic [6:0]   beats0, beats2;
  logic [2:0]   beats1;
  logic [127:0] byp0;
  logic [79:0]  byp1;
  logic [15:0]  byp2;

  // d0: N=8 single-beat groups; d1: N=5 accumulate, MAX_BEATS=4; d2: N=1 accumulate.
  add_tree_acc #(.N(8), .W(16), .ACC_EN(1'b0), .MAX_BEATS(64)) u_d0 (
    .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .last_in(last_in),
    .in_0_flat(in_0_flat), .in_1_flat(in_1_flat), .sum_out(sum0), .sum_valid(sv0),
    .sat_flag(sat0), .beats_out(beats0), .valid_bypass_out(vb0), .in_bypass_flat(byp0));

  add_tree_acc #(.N(5), .W(16), .ACC_EN(1'b1), .MAX_BEATS(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .last_in(last_in),
    .in_0_flat(in_0_flat[79:0]), .in_1_flat(in_1_flat[79:0]), .sum_out(sum1), .sum_valid(sv1),
    .sat_flag(sat1), .beats_out(beats1), .valid_bypass_out(vb1), .in_bypass_flat(byp1));

  add_tree_acc #(.N(1), .W(16), .ACC_EN(1'b1), .MAX_BEATS(64)) u_d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .last_in(last_in),
    .in_0_flat(in_0_flat[15:0]), .in_1_flat(in_1_flat[15:0]), .sum_out(sum2), .sum_valid(sv2),
    .sat_flag(sat2), .beats_out(beats2), .valid_bypass_out(vb2), .in_bypass_flat(byp2));

  int errors = 0;
  int checks = 0;
  int ecyc = 0;

  // Record: {inst[63:62], due[61:30], beats[29:22], pad[21:17], sat[16], sum[15:0]}
  logic [63:0]  exp_q[$];
  int           acc [3];
  int           cnt [3];
  bit           gsat [3];
  logic [15:0]  m_sum [3];
  logic         m_sat [3];
  logic         m_sv [3];
  logic [6:0]   m_beats [3];
  logic [128:0] m_byp [3];
  logic [128:0] dline [3][3];

  function automatic int n_of(input int j);
    return (j == 0) ? 8 : (j == 1) ? 5 : 1;
  endfunction
  function automatic int lat_of(input int j);
    return (j == 2) ? 2 : 4;
  endfunction
  function automatic int max_of(input int j);
    return (j == 1) ? 4 : 64;
  endfunction
  function automatic bit acc_of(input int j);
    return (j != 0);
  endfunction

  function automatic int clamp(input int m);
    if (m > 32767) return 32767;
    if (m < -32768) return -32768;
    return m;
  endfunction

  // Pairwise reduction with clamping at every add; returns {sat, sum}.
  function automatic logic [16:0] tree_sum(input int n, input logic [127:0] lanes);
    int v [8];
    bit s [8];
    int c;
    int m;
    for (int i = 0; i < n; i++) begin
      v[i] = int'($signed(lanes[i*16 +: 16]));
      s[i] = 1'b0;
    end
    c = n;
    while (c > 1) begin
      for (int i = 0; i < c / 2; i++) begin
        m = v[2*i] + v[2*i+1];
        s[i] = s[2*i] | s[2*i+1] | (m > 32767) | (m < -32768);
        v[i] = clamp(m);
      end
      if (c % 2 == 1) begin
        v[c/2] = v[c-1];
        s[c/2] = s[c-1];
      end
      c = (c + 1) / 2;
    end
    return {s[0], v[0][15:0]};
  endfunction

  function automatic logic [153:0] obs(input int j);
    case (j)
      0:       return {vb0, byp0, sv0, sat0, beats0, sum0};
      1:       return {vb1, 48'h0, byp1, sv1, sat1, 4'h0, beats1, sum1};
      default: return {vb2, 112'h0, byp2, sv2, sat2, beats2, sum2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [128:0] observed, input logic [128:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int j = 0; j < 3; j++) begin
      acc[j] = 0; cnt[j] = 0; gsat[j] = 1'b0;
      m_sum[j] = '0; m_sat[j] = 1'b0; m_sv[j] = 1'b0; m_beats[j] = '0; m_byp[j] = '0;
      for (int k = 0; k < 3; k++) dline[j][k] = '0;
    end
  endtask

  // One enabled clock edge of every configuration, from the inputs just sampled.
  task automatic model_edge();
    int          t, m, idx, lat;
    logic [16:0] tr;
    logic [127:0] msk;
    logic [63:0] rec;
    bit          close;
    ecyc++;
    for (int j = 0; j < 3; j++) begin
      lat = lat_of(j);
      msk = '1;
      msk = msk >> (128 - 16 * n_of(j));
      m_byp[j] = dline[j][0];
      for (int k = 0; k < lat - 2; k++) dline[j][k] = dline[j][k+1];
      dline[j][lat-2] = {valid_in, in_0_flat & msk};
      if (valid_in) begin
        tr = tree_sum(n_of(j), in_1_flat);
        t = int'($signed(tr[15:0]));
        if (cnt[j] == 0) begin
          acc[j] = t;
          gsat[j] = tr[16];
        end else begin
          m = acc[j] + t;
          gsat[j] = gsat[j] | tr[16] | (m > 32767) | (m < -32768);
          acc[j] = clamp(m);
        end
        cnt[j]++;
        close = !acc_of(j) || last_in || (cnt[j] == max_of(j));
        if (close) begin
          exp_q.push_back({2'(j), 32'(ecyc + lat - 1), 8'(cnt[j]), 5'd0, gsat[j], 16'(acc[j])});
          cnt[j] = 0;
        end
      end
      idx = -1;
      for (int q = 0; q < exp_q.size(); q++) begin
        rec = exp_q[q];
        if (idx < 0 && rec[63:62] == 2'(j)) idx = q;
      end
      m_sv[j] = 1'b0;
      if (idx >= 0) begin
        rec = exp_q[idx];
        if (rec[61:30] == 32'(ecyc)) begin
          m_sum[j] = rec[15:0];
          m_sat[j] = rec[16];
          m_beats[j] = rec[28:22];
          m_sv[j] = 1'b1;
          exp_q.delete(idx);
        end
      end
    end
  endtask

  task automatic check_all();
    logic [153:0] o;
    for (int j = 0; j < 3; j++) begin
      o = obs(j);
      chk($sformatf("d%0d_sum", j), o[15:0], m_sum[j]);
      chk($sformatf("d%0d_beats", j), o[22:16], m_beats[j]);
      chk($sformatf("d%0d_sat", j), o[23], m_sat[j]);
      chk($sformatf("d%0d_valid", j), o[24], m_sv[j]);
      chk($sformatf("d%0d_byp", j), o[152:25], m_byp[j][127:0]);
      chk($sformatf("d%0d_vbyp", j), o[153], m_byp[j][128]);
    end
  endtask

  task automatic step(input bit e, input bit v, input bit l, input logic [127:0] a0,
                      input logic [127:0] a1);
    @(negedge clk);
    en = e; valid_in = v; last_in = l; in_0_flat = a0; in_1_flat = a1;
    @(posedge clk);
    if (e && rst_n) model_edge();
    #2;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; valid_in = 1'b0; last_in = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [127:0] rand_lanes();
    logic [127:0] r;
    int sel;
    for (int i = 0; i < 8; i++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0)      r[i*16 +: 16] = 16'($urandom());
      else if (sel == 1) r[i*16 +: 16] = 16'($urandom_range(0, 4095) + 28672);
      else               r[i*16 +: 16] = 16'($urandom_range(0, 64) - 32);
    end
    return r;
  endfunction

  initial begin
    model_reset();
    do_reset();

    // Single beat through every configuration, bypass alignment.
    step(1'b1, 1'b1, 1'b1, 128'hAAA7AAA6AAA5AAA4AAA3AAA2AAA1AAA0, 128'h0008000700060005000400030002_0001);
    idle(1);
    chk("t1_sum2", sum2, 16'h0001);
    chk("t1_sv2", sv2, 1'b1);
    idle(2);
    chk("t1_sum0", sum0, 16'h0024);
    chk("t1_sv0", sv0, 1'b1);
    chk("t1_beats0", beats0, 7'd1);
    chk("t1_vb0", vb0, 1'b1);
    chk("t1_byp0", byp0, 128'hAAA7AAA6AAA5AAA4AAA3AAA2AAA1AAA0);
    chk("t1_sum1", sum1, 16'h000F);
    idle(1);
    chk("t1_pulse0", sv0, 1'b0);

    // Positive then negative saturation, back to back.
    step(1'b1, 1'b1, 1'b1, '0, {8{16'h4000}});
    step(1'b1, 1'b1, 1'b1, '0, {8{16'h8000}});
    idle(2);
    chk("t2_sum0_pos", sum0, 16'h7FFF);
    chk("t2_sat0_pos", sat0, 1'b1);
    idle(1);
    chk("t2_sum0_neg", sum0, 16'h8000);
    chk("t2_sat0_neg", sat0, 1'b1);
    idle(3);

    // Three-beat group with a bubble carrying a stray last, then a one-beat group.
    step(1'b1, 1'b1, 1'b0, '0, 128'h0000_0000_0000_0008_0002_0002_0002_0002);
    step(1'b1, 1'b0, 1'b1, '0, 128'h0);
    step(1'b1, 1'b1, 1'b0, '0, 128'h0000_0000_0000_0008_0002_0002_0002_0002);
    step(1'b1, 1'b1, 1'b1, '0, 128'h0000_0000_0000_0008_0002_0002_0002_0002);
    step(1'b1, 1'b1, 1'b1, '0, 128'h5);
    idle(2);
    chk("t4_sum1", sum1, 16'h0030);
    chk("t4_beats1", beats1, 3'd3);
    chk("t4_sv1", sv1, 1'b1);
    idle(1);
    chk("t4_sum1_b", sum1, 16'h0005);
    chk("t4_beats1_b", beats1, 3'd1);
    idle(3);

    // Forced close at MAX_BEATS=4.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, (i == 5), '0, 128'h1);
    idle(1);
    chk("t5_sum1_a", sum1, 16'h0004);
    chk("t5_beats1_a", beats1, 3'd4);
    idle(1);
    chk("t5_gap1", sv1, 1'b0);
    idle(1);
    chk("t5_sum1_b", sum1, 16'h0002);
    chk("t5_beats1_b", beats1, 3'd2);
    idle(3);

    // Stall: inputs presented while en=0 must be ignored.
    step(1'b1, 1'b1, 1'b1, '0, 128'h7);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, '1, '1);
    idle(1);
    chk("t6_early1", sv1, 1'b0);
    idle(1);
    chk("t6_sum1", sum1, 16'h0007);
    chk("t6_sv1", sv1, 1'b1);
    idle(3);

    // Reset mid-group drops the partial sum.
    step(1'b1, 1'b1, 1'b0, '0, 128'h9);
    step(1'b1, 1'b1, 1'b0, '0, 128'h9);
    do_reset();
    chk("t7_rst_sum1", sum1, 16'h0000);
    step(1'b1, 1'b1, 1'b1, '0, 128'h3);
    idle(3);
    chk("t7_sum1", sum1, 16'h0003);
    chk("t7_beats1", beats1, 3'd1);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
           {$urandom(), $urandom(), $urandom(), $urandom()}, rand_lanes());
    end
    idle(10);
    chk("drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
